frame_uart_tx: RTL

- Streams one stored image frame from the SDRAM read path back to the host PC over RS-232 UART. It is the transmit counterpart of the UART-receive to SDRAM image-load path.
- On a `start` pulse the block sends a 2-byte sync header, then IMG_H*IMG_V 16-bit pixels, high byte first, 8N1 framing.
- Pixels are pulled through a valid/ready handshake; the upstream source is typically the SDRAM controller read FIFO.
- Runs in the 50 MHz UART clock domain.

---
 rtl/frame_uart_tx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/frame_uart_tx.sv
// ============================================================================
// Module   : frame_uart_tx
// Purpose  : Sends a sync header then one image frame of 16-bit pixels over 8N1 UART.
// Revision : 1.0
// ============================================================================
`default_nettype none

module frame_uart_tx #(
   parameter int          CLK_FREQ = 50_000_000,
   parameter int          BAUD     = 115200,
   parameter int          IMG_H    = 800,
   parameter int          IMG_V    = 480,
   parameter logic [7:0]  HDR0     = 8'hA5,
   parameter logic [7:0]  HDR1     = 8'h5A
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        Rs232_tx,
   output logic        busy,
   output logic        done
);

   localparam int BAUD_DIV  = CLK_FREQ / BAUD;
   localparam int PIX_TOTAL = IMG_H * IMG_V;
   localparam int BCW       = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam int PCW       = $clog2(PIX_TOTAL + 1);
   localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
   localparam logic [PCW-1:0] PIX_LAST  = PCW'(PIX_TOTAL);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_PIX  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             hdr_sel_q, hdr_sel_d;
   logic [15:0]      buf_q, buf_d;
   logic             buf_full_q, buf_full_d;
   logic             lo_pend_q, lo_pend_d;
   logic [PCW-1:0]   acc_q, acc_d;

   logic             tx_q;
   logic             sh_active_q;
   logic [BCW-1:0]   baud_q;
   logic [3:0]       bit_q;
   logic [8:0]       shift_q;

   logic             sh_done;
   logic             sh_free;
   logic             load;
   logic [7:0]       load_byte;
   logic             xfer;

   assign sh_done   = sh_active_q && (bit_q == 4'd9) && (baud_q == BAUD_LAST);
   assign sh_free   = !sh_active_q || sh_done;
   assign pix_ready = (state_q == S_PIX) && !buf_full_q && (acc_q < PIX_LAST);
   assign xfer      = pix_valid && pix_ready;

   assign Rs232_tx  = tx_q;
   assign busy      = busy_q;
   assign done      = done_q;

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      hdr_sel_d  = hdr_sel_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      lo_pend_d  = lo_pend_q;
      acc_d      = acc_q;
      load       = 1'b0;
      load_byte  = 8'h00;

      case (state_q)
         S_IDLE: begin
            // A start landing on the done cycle is dropped, not queued.
            if (start && !done_q) begin
               state_d    = S_HDR;
               busy_d     = 1'b1;
               hdr_sel_d  = 1'b0;
               buf_full_d = 1'b0;
               lo_pend_d  = 1'b0;
               acc_d      = '0;
            end
         end
         S_HDR: begin
            if (sh_free) begin
               load = 1'b1;
               if (!hdr_sel_q) begin
                  load_byte = HDR0;
                  hdr_sel_d = 1'b1;
               end else begin
                  load_byte = HDR1;
                  state_d   = S_PIX;
               end
            end
         end
         S_PIX: begin
            if (xfer) begin
               buf_d      = pix_data;
               buf_full_d = 1'b1;
               acc_d      = acc_q + 1'b1;
            end
            if (sh_free) begin
               if (lo_pend_q) begin
                  // Low byte is copied out, so the buffer may refill while it shifts.
                  load       = 1'b1;
                  load_byte  = buf_q[7:0];
                  lo_pend_d  = 1'b0;
                  buf_full_d = 1'b0;
               end else if (buf_full_q) begin
                  load       = 1'b1;
                  load_byte  = buf_q[15:8];
                  lo_pend_d  = 1'b1;
               end else if (acc_q == PIX_LAST) begin
                  state_d    = S_FIN;
               end
            end
         end
         S_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         hdr_sel_q  <= 1'b0;
         buf_q      <= 16'h0000;
         buf_full_q <= 1'b0;
         lo_pend_q  <= 1'b0;
         acc_q      <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         hdr_sel_q  <= hdr_sel_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         lo_pend_q  <= lo_pend_d;
         acc_q      <= acc_d;
      end
   end

   // shift_q holds the bits still to send, with the stop bit parked in bit 8.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_q        <= 1'b1;
         sh_active_q <= 1'b0;
         baud_q      <= '0;
         bit_q       <= 4'd0;
         shift_q     <= 9'h1FF;
      end else if (load) begin
         tx_q        <= 1'b0;
         sh_active_q <= 1'b1;
         baud_q      <= '0;
         bit_q       <= 4'd0;
         shift_q     <= {1'b1, load_byte};
      end else if (sh_active_q) begin
         if (baud_q != BAUD_LAST) begin
            baud_q <= baud_q + 1'b1;
         end else if (sh_done) begin
            sh_active_q <= 1'b0;
            tx_q        <= 1'b1;
            baud_q      <= '0;
         end else begin
            baud_q  <= '0;
            bit_q   <= bit_q + 4'd1;
            tx_q    <= shift_q[0];
            shift_q <= {1'b1, shift_q[8:1]};
         end
      end
   end

endmodule

`default_nettype wire
